// File: rtl/gtx_qpll_pkg.sv
// Shared types and constants for the GTXE2_COMMON QPLL reset/lock sequencer.
package gtx_qpll_pkg;

   // Sequencer states; the codes are visible on the STATE debug port.
   typedef enum logic [2:0] {
      ST_PWRDN     = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_READY     = 3'd4,
      ST_FAIL      = 3'd5
   } qpll_state_e;

   // Registered control outputs, decoded from the state.
   typedef struct packed {
      logic pd;
      logic rst;
      logic locken;
      logic ready;
      logic fail;
   } qpll_ctrl_t;

   // Values the control outputs take while RST_N is low.
   localparam logic RST_VAL_PD     = 1'b1;
   localparam logic RST_VAL_RESET  = 1'b1;
   localparam logic RST_VAL_LOCKEN = 1'b0;
   localparam logic RST_VAL_READY  = 1'b0;
   localparam logic RST_VAL_FAIL   = 1'b0;

   localparam qpll_ctrl_t CTRL_RESET_VAL = '{
      pd:     RST_VAL_PD,
      rst:    RST_VAL_RESET,
      locken: RST_VAL_LOCKEN,
      ready:  RST_VAL_READY,
      fail:   RST_VAL_FAIL
   };

   // Output decode for a given state.
   function automatic qpll_ctrl_t decode_ctrl(input qpll_state_e st);
      qpll_ctrl_t c;
      c = CTRL_RESET_VAL;
      case (st)
         ST_PWRDN:     c = '{pd: 1'b1, rst: 1'b1, locken: 1'b0, ready: 1'b0, fail: 1'b0};
         ST_RESET:     c = '{pd: 1'b0, rst: 1'b1, locken: 1'b1, ready: 1'b0, fail: 1'b0};
         ST_WAIT_LOCK: c = '{pd: 1'b0, rst: 1'b0, locken: 1'b1, ready: 1'b0, fail: 1'b0};
         ST_STABLE:    c = '{pd: 1'b0, rst: 1'b0, locken: 1'b1, ready: 1'b0, fail: 1'b0};
         ST_READY:     c = '{pd: 1'b0, rst: 1'b0, locken: 1'b1, ready: 1'b1, fail: 1'b0};
         ST_FAIL:      c = '{pd: 1'b0, rst: 1'b1, locken: 1'b1, ready: 1'b0, fail: 1'b1};
         default:      c = CTRL_RESET_VAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/gtx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module gtx_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic stage_p0;
   logic stage_p1;

   // Metastability filter: first flop samples the async level, second re-times it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_p0 <= 1'b0;
         stage_p1 <= 1'b0;
      end else begin
         stage_p0 <= d;
         stage_p1 <= stage_p0;
      end
   end

   assign q = stage_p1;

endmodule

// File: rtl/gtx_qpll_reset_seq.sv
// Reset and lock sequencer for one GTXE2_COMMON QPLL: power-down, reset pulse,
// lock wait with timeout, stability window, retry counting and terminal failure.
module gtx_qpll_reset_seq
   import gtx_qpll_pkg::*;
#(
   parameter int PD_CYCLES     = 16,
   parameter int RESET_CYCLES  = 32,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 24
) (
   input  logic       DRPCLK,
   input  logic       RST_N,
   input  logic       SOFT_RESET,
   input  logic       QPLLLOCK,
   input  logic       QPLLREFCLKLOST,
   output logic       QPLLPD,
   output logic       QPLLRESET,
   output logic       QPLLLOCKEN,
   output logic       QPLL_READY,
   output logic       QPLL_FAIL,
   output logic [3:0] RETRY_CNT,
   output logic [2:0] STATE
);

   // Every terminal count must fit the counter so no compare is ever skipped by a wrap.
   generate
      if (CNT_W < 2 || CNT_W > 31 ||
          PD_CYCLES < 1 || PD_CYCLES >= (1 << CNT_W) ||
          RESET_CYCLES < 1 || RESET_CYCLES >= (1 << CNT_W) ||
          LOCK_TIMEOUT < 1 || LOCK_TIMEOUT >= (1 << CNT_W) ||
          STABLE_CYCLES < 1 || STABLE_CYCLES >= (1 << CNT_W) ||
          MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_params
         $error("gtx_qpll_reset_seq: cycle-count or retry parameter out of range");
      end
   endgenerate

   localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

   qpll_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [3:0]       retry_inc;
   logic             attempt_failed;
   qpll_ctrl_t       ctrl_q;
   logic             lock_s;
   logic             lost_s;

   gtx_sync_2ff u_sync_lock (
      .clk   (DRPCLK),
      .rst_n (RST_N),
      .d     (QPLLLOCK),
      .q     (lock_s)
   );

   gtx_sync_2ff u_sync_lost (
      .clk   (DRPCLK),
      .rst_n (RST_N),
      .d     (QPLLREFCLKLOST),
      .q     (lost_s)
   );

   assign retry_inc = retry_q + 4'd1;

   // Next-state, counter and retry bookkeeping; soft reset overrides everything.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      retry_d        = retry_q;
      attempt_failed = 1'b0;
      if (SOFT_RESET) begin
         state_d = ST_PWRDN;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_PWRDN: begin
               if (cnt_q == PD_LAST) begin
                  state_d = ST_RESET;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RESET: begin
               // A missing reference clock keeps the reset window from starting.
               if (lost_s) begin
                  cnt_d = '0;
               end else if (cnt_q == RESET_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_WAIT_LOCK: begin
               // Lost refclk beats lock; lock beats a same-cycle timeout.
               if (lost_s) begin
                  state_d = ST_RESET;
                  cnt_d   = '0;
               end else if (lock_s) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  attempt_failed = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_STABLE: begin
               if (lost_s) begin
                  state_d = ST_RESET;
                  cnt_d   = '0;
               end else if (!lock_s) begin
                  attempt_failed = 1'b1;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_READY;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_READY: begin
               // Losing lock after READY is not counted as a failed attempt.
               if (!lock_s || lost_s) begin
                  state_d = ST_RESET;
                  cnt_d   = '0;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_PWRDN;
               cnt_d   = '0;
            end
         endcase
         if (attempt_failed) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
         end
      end
   end

   // State, counter, retry count and output registers; outputs track the next state.
   always_ff @(posedge DRPCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_PWRDN;
         cnt_q   <= '0;
         retry_q <= '0;
         ctrl_q  <= CTRL_RESET_VAL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         ctrl_q  <= decode_ctrl(state_d);
      end
   end

   assign QPLLPD     = ctrl_q.pd;
   assign QPLLRESET  = ctrl_q.rst;
   assign QPLLLOCKEN = ctrl_q.locken;
   assign QPLL_READY = ctrl_q.ready;
   assign QPLL_FAIL  = ctrl_q.fail;
   assign RETRY_CNT  = retry_q;
   assign STATE      = state_q;

endmodule

// File: doc/gtx_qpll_reset_seq.md
Name: gtx_qpll_reset_seq

Overview:
Reset and lock sequencer for one GTXE2_COMMON quad PLL. It drives QPLLPD, QPLLRESET and QPLLLOCKEN into the common block, and synchronises QPLLLOCK and QPLLREFCLKLOST back into its own clock domain. Failed lock attempts are retried up to a limit; after that it reports failure. The channel reset sequencers downstream use QPLL_READY as their "PLL good" qualifier.

Parameters:
PD_CYCLES, 16, cycles QPLLPD is held high at power-up or soft reset (min 1)
RESET_CYCLES, 32, cycles QPLLRESET is held high per attempt (min 1)
LOCK_TIMEOUT, 50000, cycles allowed for the synced lock to rise after reset release
STABLE_CYCLES, 1024, cycles the synced lock must stay high before READY
MAX_RETRIES, 3, failed attempts allowed before FAIL (1..15)
CNT_W, 24, cycle counter width; every cycle-count parameter must be < 2**CNT_W (elaboration check)

Ports:
DRPCLK  in  1  free-running sequencer clock (same clock as the QPLL DRP and lock-detect clock)
RST_N  in  1  asynchronous active-low reset
SOFT_RESET  in  1  synchronous single-cycle request to restart the full sequence
QPLLLOCK  in  1  QPLL lock, asynchronous to DRPCLK
QPLLREFCLKLOST  in  1  reference clock lost, asynchronous to DRPCLK
QPLLPD  out  1  QPLL power-down
QPLLRESET  out  1  QPLL reset
QPLLLOCKEN  out  1  lock detector enable
QPLL_READY  out  1  PLL locked and stable
QPLL_FAIL  out  1  retry limit exhausted
RETRY_CNT  out  4  count of failed attempts in the current sequence
STATE  out  3  current state encoding, for debug

Behaviour:
- Reset: while RST_N=0, all outputs are asynchronously forced:
  - QPLLPD=1, QPLLRESET=1, QPLLLOCKEN=0, QPLL_READY=0, QPLL_FAIL=0, RETRY_CNT=0.
  - State=PWRDN, counter=0.
- Synchronisers: QPLLLOCK and QPLLREFCLKLOST each pass through a 2-flop synchroniser (lock_s, lost_s). Both flops reset to 0. This adds 2 cycles of latency. The FSM uses only lock_s and lost_s.
- All outputs are registered and decoded from the state:
  - PWRDN: PD=1, RST=1, LOCKEN=0.
  - RESET: PD=0, RST=1, LOCKEN=1.
  - WAIT_LOCK, STABLE, READY: PD=0, RST=0, LOCKEN=1.
  - FAIL: PD=0, RST=1, LOCKEN=1.
  - QPLL_READY=1 only in READY. QPLL_FAIL=1 only in FAIL.
- State encoding: PWRDN=0, RESET=1, WAIT_LOCK=2, STABLE=3, READY=4, FAIL=5.
- The counter clears on every state entry.
- PWRDN: counter increments. At counter==PD_CYCLES-1, go to RESET, so QPLLPD is high for exactly PD_CYCLES cycles after reset release.
- RESET: counter increments while lost_s=0 and holds at 0 while lost_s=1. At counter==RESET_CYCLES-1 with lost_s=0, go to WAIT_LOCK.
- WAIT_LOCK:
  - lost_s=1: go to RESET, RETRY_CNT unchanged.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1: failed attempt.
- STABLE:
  - lost_s=1: go to RESET, RETRY_CNT unchanged.
  - lock_s=0: failed attempt.
  - Counter reaches STABLE_CYCLES-1 with lock_s=1: go to READY and clear RETRY_CNT.
- Failed attempt: RETRY_CNT increments. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to RESET.
- READY: if lock_s=0 or lost_s=1, go to RESET with QPLL_READY deasserted on the same edge. RETRY_CNT stays 0.
- FAIL: terminal. Exits only on SOFT_RESET or RST_N.
- SOFT_RESET=1 in any state, including mid-count in PWRDN: go to PWRDN, counter=0, RETRY_CNT=0. It has priority over all other transitions in the same cycle.
- Simultaneous lost_s and lock_s in WAIT_LOCK: lost_s wins.
- Simultaneous timeout and lock_s=1 on the same cycle: lock wins, go to STABLE.
- The counter never wraps; each terminal compare fires before 2**CNT_W-1.
- STATE outputs the registered state code.

Decomposition:
- Package gtx_qpll_pkg:
  - State localparams (3-bit codes above).
  - Reset-value constants for the control outputs.
- Sub-module gtx_sync_2ff: 1-bit, 2-stage synchroniser with asynchronous active-low reset to 0. Instantiated twice.
- FSM, counter and retry logic stay flat in gtx_qpll_reset_seq.

Test Plan:
Bench parameters for all scenarios: PD_CYCLES=4, RESET_CYCLES=8, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRIES=3.
1. Release RST_N with QPLLLOCK rising 20 cycles after QPLLRESET falls -> QPLLPD high 4 cycles, QPLLRESET high 4+8 cycles, STABLE entered 2 cycles after QPLLLOCK rises, QPLL_READY=1 16 cycles later, RETRY_CNT=0.
2. QPLLLOCK held 0 -> three timeouts of 100 cycles each, RETRY_CNT steps 1,2,3, then STATE=5, QPLL_FAIL=1, QPLLRESET=1 held.
3. Lock glitches low for 3 cycles mid-STABLE -> RETRY_CNT=1, return to RESET; a clean second lock reaches READY with RETRY_CNT=0.
4. In READY, assert QPLLREFCLKLOST for 50 cycles -> QPLL_READY drops 2-3 cycles after assertion; QPLLRESET is held for all 50 cycles plus 8 after lost clears; RETRY_CNT stays 0.
5. In FAIL, pulse SOFT_RESET -> STATE=0 next cycle, QPLLPD=1, RETRY_CNT=0; the full sequence repeats.
6. Assert RST_N=0 asynchronously mid-WAIT_LOCK -> outputs take reset values immediately without a clock edge; a SOFT_RESET coincident with lock_s rising in WAIT_LOCK -> PWRDN.
